// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes x - y LSB-first, one bit per clock,
// through a single full-subtractor slice built from two half-subtractor cells.

module HalfSubtractor (
    input  logic x,
    input  logic y,
    output logic xy,
    output logic borrowOut
);

    assign xy        = x ^ y;
    assign borrowOut = ~x & y;

endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrowOut
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_xs;
    logic [WIDTH-1:0] r_ys;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_b;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic             w_xy1;
    logic             w_b1;
    logic             w_d;
    logic             w_b2;
    logic             w_bn;
    logic [WIDTH-1:0] w_acc_next;

    // Full-subtractor slice: first cell takes xs-ys, second subtracts the stored borrow.
    HalfSubtractor u_hs_a (
        .x         (r_xs[0]),
        .y         (r_ys[0]),
        .xy        (w_xy1),
        .borrowOut (w_b1)
    );

    HalfSubtractor u_hs_b (
        .x         (w_xy1),
        .y         (r_b),
        .xy        (w_d),
        .borrowOut (w_b2)
    );

    assign w_bn       = w_b1 | w_b2;
    assign w_acc_next = {w_d, r_acc[WIDTH-1:1]};

    // Sequencer, operand shifters, borrow storage and held result registers.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state  <= ST_IDLE;
            r_xs     <= '0;
            r_ys     <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_b      <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ST_SHIFT;
                        r_xs    <= x;
                        r_ys    <= y;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_b     <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    r_xs  <= {1'b0, r_xs[WIDTH-1:1]};
                    r_ys  <= {1'b0, r_ys[WIDTH-1:1]};
                    r_acc <= w_acc_next;
                    r_b   <= w_bn;
                    r_cnt <= r_cnt + CW'(1);
                    // The MSB slice result goes straight to the outputs on the same edge.
                    if (r_cnt == LAST_BIT) begin
                        r_state  <= ST_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_diff   <= w_acc_next;
                        r_borrow <= w_bn;
                    end else begin
                        r_state <= ST_SHIFT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign diff      = r_diff;
    assign borrowOut = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus random operands
// checked against plain modular arithmetic.

module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         nReset;
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrowOut;

    int           n_checks;
    int           n_fail;
    logic [W-1:0] held_d;
    logic         held_b;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .nReset    (nReset),
        .start     (start),
        .x         (x),
        .y         (y),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .borrowOut (borrowOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge after the accepting edge; returns in the done cycle.
    task automatic expect_run(input logic [W-1:0] xv, input logic [W-1:0] yv,
                              input int ignore_at, input bit hold);
        logic [W-1:0] exp_d;
        logic         exp_b;
        exp_d = W'(xv - yv);
        exp_b = (xv < yv) ? 1'b1 : 1'b0;
        for (int i = 0; i < W; i++) begin
            check("busy_in_shift", 32'(busy), 32'd1);
            check("no_done_in_shift", 32'(done), 32'd0);
            check("diff_held", 32'(diff), 32'(held_d));
            check("borrow_held", 32'(borrowOut), 32'(held_b));
            if (i == ignore_at) begin
                start = 1'b1;
                x     = 8'h00;
                y     = 8'hFF;
            end else begin
                if (!hold) start = 1'b0;
                x = 8'($urandom);
                y = 8'($urandom);
            end
            @(negedge clk);
        end
        check("done_pulse", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("diff_result", 32'(diff), 32'(exp_d));
        check("borrow_result", 32'(borrowOut), 32'(exp_b));
        held_d = exp_d;
        held_b = exp_b;
    endtask

    task automatic do_op(input logic [W-1:0] xv, input logic [W-1:0] yv, input int ignore_at);
        start = 1'b1;
        x     = xv;
        y     = yv;
        @(negedge clk);
        expect_run(xv, yv, ignore_at, 1'b0);
        start = 1'b0;
        @(negedge clk);
        check("done_single", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_diff", 32'(diff), 32'(held_d));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        held_d   = '0;
        held_b   = 1'b0;
        nReset   = 1'b0;
        start    = 1'b0;
        x        = '0;
        y        = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrowOut), 32'd0);
        nReset = 1'b1;
        @(negedge clk);
        check("idle_after_rst", 32'(busy), 32'd0);

        do_op(8'h5A, 8'h23, -1);
        do_op(8'h00, 8'h01, -1);
        do_op(8'h80, 8'h81, -1);
        do_op(8'hFF, 8'hFF, -1);
        do_op(8'hFF, 8'h00, -1);
        do_op(8'h10, 8'h01, 3);
        do_op(8'h20, 8'h10, -1);

        // Abort mid-operation with reset.
        start = 1'b1;
        x     = 8'h09;
        y     = 8'h05;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_abort", 32'(busy), 32'd1);
        nReset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrowOut), 32'd0);
        held_d = '0;
        held_b = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2) nReset = 1'b1;
            check("no_done_after_abort", 32'(done), 32'd0);
            check("idle_after_abort", 32'(busy), 32'd0);
        end
        do_op(8'h09, 8'h05, -1);

        // Back-to-back with start held high.
        start = 1'b1;
        x     = 8'h03;
        y     = 8'h05;
        @(negedge clk);
        expect_run(8'h03, 8'h05, -1, 1'b1);
        x = 8'h07;
        y = 8'h02;
        @(negedge clk);
        expect_run(8'h07, 8'h02, -1, 1'b1);
        start = 1'b0;
        @(negedge clk);
        check("b2b_end_done", 32'(done), 32'd0);
        check("b2b_end_busy", 32'(busy), 32'd0);

        for (int k = 0; k < 24; k++) begin
            do_op(8'($urandom), 8'($urandom), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor that computes x - y LSB-first, one bit per clock, with a registered borrow.
The per-bit datapath is one full-subtractor slice: two HalfSubtractor instances plus a 2-input OR on their borrows.
It sits downstream of the HalfSubtractor cell: it consumes the cell's xy/borrowOut outputs and adds the sequencing, borrow storage and result buffering.
It serves as the area-minimal subtract unit for the D2 datapath.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
nReset  input  1  asynchronous active-low reset
start  input  1  request to begin an operation; sampled at the rising edge
x  input  WIDTH  minuend; captured on an accepted start
y  input  WIDTH  subtrahend; captured on an accepted start
busy  output  1  high while the operation is in progress (SHIFT state)
done  output  1  one-cycle pulse when diff and borrowOut become valid
diff  output  WIDTH  result x - y mod 2^WIDTH; held until the next completion
borrowOut  output  1  final borrow (1 when x < y unsigned); held with diff

Behaviour:
- Reset is asynchronous and active-low. While nReset=0:
  - FSM goes to IDLE.
  - busy=0, done=0, diff=0, borrowOut=0.
  - Shift registers, borrow flip-flop and bit counter are all cleared.
- FSM states and transitions:
  - IDLE -> SHIFT when start=1.
  - SHIFT -> DONE when the bit counter reaches WIDTH-1. The counter is cleared on start and increments each SHIFT cycle.
  - DONE -> SHIFT when start=1; otherwise DONE -> IDLE.
- Accepting a start (in IDLE or DONE):
  - x and y are loaded into shift registers xs and ys.
  - The borrow flip-flop b is cleared to 0 and the counter to 0.
  - Start is accepted only in IDLE or DONE. start=1 during SHIFT is ignored and has no effect on the operation in progress.
- Each SHIFT cycle:
  - Slice computes d = xs[0]^ys[0]^b.
  - Slice computes bn = (~xs[0]&ys[0]) | (~(xs[0]^ys[0])&b).
  - xs and ys shift right by one.
  - d is inserted at the MSB of an internal accumulator, which also shifts right.
  - b <= bn.
- Completion (final SHIFT edge):
  - The complete accumulator is copied to diff and bn to borrowOut on the same edge.
  - FSM enters DONE; done=1 for exactly that one cycle.
- Timing:
  - busy=1 exactly in SHIFT, i.e. WIDTH cycles.
  - Latency from the accepting edge to done=1 is WIDTH+1 edges... precisely: start sampled at edge E0; done is high in the cycle after edge E_WIDTH.
- Output stability:
  - diff and borrowOut change only at the completion edge or on reset.
  - The accumulator is internal, so outputs never show partial results.
- Back-to-back operation:
  - start=1 while in DONE begins the next operation at that edge.
  - done deasserts and busy asserts on that same edge.
  - Throughput is one result every WIDTH+1 cycles.
- Arithmetic:
  - Unsigned; the result wraps modulo 2^WIDTH.
  - borrowOut equals the borrow out of the MSB slice.
- Reset asserted mid-operation:
  - Aborts immediately; all state and outputs go to their reset values.
  - No done pulse is produced.
  - After nReset rises, the block waits in IDLE for a new start.
- x and y may change freely after the accepting edge; they are not sampled again.

Test Plan:
1. WIDTH=8, x=0x5A, y=0x23, start pulse -> busy high for 8 cycles; done pulses 9 edges after start; diff=0x37, borrowOut=0.
2. x=0x00, y=0x01 -> diff=0xFF, borrowOut=1. Separately, x=0x80, y=0x81 -> diff=0xFF, borrowOut=1.
3. x=0xFF, y=0xFF -> diff=0x00, borrowOut=0. Then x=0xFF, y=0x00 -> diff=0xFF, borrowOut=0.
4. Start x=0x10, y=0x01; after 3 cycles assert start with x=0x00, y=0xFF -> second start ignored; result diff=0x0F, borrowOut=0; exactly one done pulse.
5. Complete x=0x20, y=0x10 (diff=0x10). Start x=0x09, y=0x05, then drop nReset after 4 SHIFT cycles -> busy=0, diff=0x00, borrowOut=0 immediately; no done. Re-run x=0x09, y=0x05 after release -> diff=0x04.
6. Hold start=1 continuously with x=0x03, y=0x05 then x=0x07, y=0x02 presented in the DONE cycle -> done pulses every 9 cycles; results 0xFE/borrowOut=1, then 0x05/borrowOut=0; diff stable between the pulses.
